// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline: opcodes, funct3 encodings,
// the control word carried between stages, and the MA stage FSM states.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // An all-zero control word is a pipeline bubble.
  typedef struct packed {
    rv32i_opcode opcode;
    logic [31:0] u_imm;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    ma_idle = 2'b00,
    ma_busy = 2'b01,
    ma_done = 2'b10
  } ma_state_t;

  function automatic logic is_mem_op(input rv32i_opcode op);
    return (op == op_load) || (op == op_store);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: shift the cache word down by the byte offset, then
// sign- or zero-extend according to the load funct3. Misaligned halves and
// words are not trapped; bits shifted in from the top are zero.
import rv32i_types::*;

module load_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift to the addressed byte and extend per load width.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (load_funct3_t'(funct3))
      lb:      data = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     data = {24'b0, shifted[7:0]};
      lh:      data = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MA pipeline stage: data-cache handshake with stall generation, store data
// shifting, load alignment, writeback value selection and the MA/WB register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ma_idle | no access outstanding; a memory op issues its request here
// ma_busy | request outstanding, waiting for dmem_resp
// ma_done | response captured while frozen; waiting for freeze to drop
import rv32i_types::*;

module memory_access_stage (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic [1:0]        addr_offset_in,
  input  logic              freeze_in,
  output logic [31:0]       dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              ma_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       wb_data_out,
  output logic [31:0]       rvfi_mem_addr,
  output logic [31:0]       rvfi_mem_rdata,
  output logic [31:0]       rvfi_mem_wdata,
  output logic [3:0]        rvfi_mem_rmask,
  output logic [3:0]        rvfi_mem_wmask
);

  ma_state_t   state;
  logic [31:0] rdata_hold;
  logic        mem_op;
  logic        is_load;
  logic        is_store;
  logic        req_active;
  logic [2:0]  funct3;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic [31:0] wb_value;

  assign funct3   = instruction_in[14:12];
  assign mem_op   = is_mem_op(ctrl_word_in.opcode);
  assign is_load  = (ctrl_word_in.opcode == op_load);
  assign is_store = (ctrl_word_in.opcode == op_store);

  // The request is live on a fresh memory op in idle and throughout busy.
  assign req_active = ((state == ma_idle) && mem_op) || (state == ma_busy);

  assign dmem_address = {alu_in[31:2], 2'b00};
  assign dmem_read    = req_active && is_load;
  assign dmem_write   = req_active && is_store;
  assign dmem_wmask   = mem_byte_enable_in;
  assign dmem_wdata   = rs2_in << {addr_offset_in, 3'b000};

  assign ma_stall = mem_op && (state != ma_done) && !dmem_resp;

  // In done the cache has already answered; only the held copy is valid.
  assign rdata_sel = (state == ma_done) ? rdata_hold : dmem_rdata;

  load_align u_load_align (
    .funct3 (funct3),
    .offset (addr_offset_in),
    .rdata  (rdata_sel),
    .data   (load_data)
  );

  // Resolve the value that writeback will commit.
  always_comb begin
    wb_value = alu_in;
    case (ctrl_word_in.opcode)
      op_load:         wb_value = load_data;
      op_lui:          wb_value = ctrl_word_in.u_imm;
      op_imm, op_reg:  if (funct3 == 3'b010 || funct3 == 3'b011)
                         wb_value = {31'b0, br_en_in};
      op_jal, op_jalr: wb_value = pc_in + 32'd4;
      default:         wb_value = alu_in;
    endcase
  end

  // Access FSM and response capture; a response is captured exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ma_idle;
      rdata_hold <= '0;
    end else begin
      case (state)
        ma_idle: begin
          if (mem_op && dmem_resp) rdata_hold <= dmem_rdata;
          if (mem_op && !dmem_resp)             state <= ma_busy;
          else if (mem_op && dmem_resp && freeze_in) state <= ma_done;
        end
        ma_busy: begin
          if (dmem_resp) begin
            rdata_hold <= dmem_rdata;
            state      <= freeze_in ? ma_done : ma_idle;
          end
        end
        ma_done: begin
          if (!freeze_in) state <= ma_idle;
        end
        default: state <= ma_idle;
      endcase
    end
  end

  // MA/WB register: advance when free, insert a bubble while stalled, hold on freeze.
  always_ff @(posedge clk) begin
    if (rst || (ma_stall && !freeze_in)) begin
      ctrl_word_out   <= '0;
      instruction_out <= '0;
      pc_out          <= '0;
      wb_data_out     <= '0;
      rvfi_mem_addr   <= '0;
      rvfi_mem_rdata  <= '0;
      rvfi_mem_wdata  <= '0;
      rvfi_mem_rmask  <= '0;
      rvfi_mem_wmask  <= '0;
    end else if (!freeze_in) begin
      ctrl_word_out   <= ctrl_word_in;
      instruction_out <= instruction_in;
      pc_out          <= pc_in;
      wb_data_out     <= wb_value;
      rvfi_mem_addr   <= mem_op ? dmem_address : 32'b0;
      rvfi_mem_rdata  <= is_load ? rdata_sel : 32'b0;
      rvfi_mem_wdata  <= is_store ? dmem_wdata : 32'b0;
      rvfi_mem_rmask  <= is_load ? mem_byte_enable_in : 4'b0;
      rvfi_mem_wmask  <= is_store ? mem_byte_enable_in : 4'b0;
    end
  end

endmodule
